// File: rtl/load_store_unit.sv
// Load/store unit: one CPU access per request, range/alignment fault checks, load extension.
// Optional LSU_MISALIGN_SPLIT_EN executes misaligned in-range accesses as ascending byte accesses.
module load_store_unit #(
  parameter int unsigned ADDR_LIMIT = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_read_data
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        wr_q, uns_q, fault_q;
  logic [1:0]  size_q, cnt_q;
  logic [31:0] addr_q, wdata_q, rdata_q, asm_q, asm_next;
  logic        accept, aligned, in_range, split_last;
  logic [2:0]  req_nb;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] s,
                                         input logic u);
    case (s)
      2'b00:   extend = {{24{~u & d[7]}}, d[7:0]};
      2'b01:   extend = {{16{~u & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_nb    = (req_size == 2'b00) ? 3'd1 : (req_size == 2'b01) ? 3'd2 : 3'd4;
  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign in_range  = ({1'b0, req_addr} + {30'b0, req_nb}) <= {1'b0, ADDR_LIMIT};
  assign aligned   = (req_size == 2'b00) ? 1'b1 :
                     (req_size == 2'b01) ? ~req_addr[0] : (req_addr[1:0] == 2'b00);
  assign split_last = (cnt_q == ((size_q == 2'b01) ? 2'd1 : 2'd3));

  always_comb begin
    asm_next = asm_q;
    asm_next[{cnt_q, 3'b000} +: 8] = mem_read_data[7:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (!in_range)    state_d = RESP;
        else if (aligned) state_d = ACCESS;
        else if (SplitEn) state_d = SPLIT;
        else              state_d = RESP;
      end
      ACCESS:  state_d = RESP;
      SPLIT:   if (split_last) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 32'h0;
    mem_write_data = 32'h0;
    mem_size       = 2'b00;
    if (state_q == ACCESS) begin
      mem_read       = ~wr_q;
      mem_write      = wr_q;
      mem_address    = addr_q;
      mem_write_data = wdata_q;
      mem_size       = (size_q == 2'b11) ? 2'b10 : size_q;
    end else if (state_q == SPLIT) begin
      mem_read       = ~wr_q;
      mem_write      = wr_q;
      mem_address    = addr_q + {30'b0, cnt_q};
      mem_write_data = {24'h0, wdata_q[{cnt_q, 3'b000} +: 8]};
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_fault = resp_valid && fault_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'b00;
      cnt_q   <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      asm_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          wr_q    <= req_write;
          uns_q   <= req_unsigned;
          size_q  <= req_size;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          fault_q <= !in_range || (!aligned && !SplitEn);
          cnt_q   <= 2'b00;
          rdata_q <= 32'h0;
          asm_q   <= 32'h0;
        end
        ACCESS: if (!wr_q) rdata_q <= extend(mem_read_data, size_q, uns_q);
        SPLIT: begin
          cnt_q <= cnt_q + 2'd1;
          if (!wr_q) begin
            asm_q <= asm_next;
            if (split_last) rdata_q <= extend(asm_next, size_q, uns_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
